// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed 7-segment scan decoder:
//   - segment patterns for digits 0..9 and blank, bit order ABCDEFG
//     (bit 6 = segment A, bit 0 = segment G), active-high
//   - BCD code reported for a blank digit
//   - settle counter width
//   - scan FSM state encoding
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Wide enough for the largest legal settle length (255).
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        SYNC,
        SETTLE,
        HOLD
    } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// -----------------------------------------------------------------------------
// seg7_to_bcd
// Combinational inverse of the BCD-to-7-segment encoder.
// Ports:
//   seg_i   [6:0]  segment pattern, ABCDEFG, active-high
//   bcd_o   [3:0]  decoded digit 0..9, or BCD_BLANK for a blank / illegal pattern
//   legal_o        1 when seg_i is one of the ten digit patterns or blank
// -----------------------------------------------------------------------------
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       legal_o
);

    always_comb begin
        bcd_o   = BCD_BLANK;
        legal_o = 1'b1;
        case (seg_i)
            SEG_0:     bcd_o = 4'd0;
            SEG_1:     bcd_o = 4'd1;
            SEG_2:     bcd_o = 4'd2;
            SEG_3:     bcd_o = 4'd3;
            SEG_4:     bcd_o = 4'd4;
            SEG_5:     bcd_o = 4'd5;
            SEG_6:     bcd_o = 4'd6;
            SEG_7:     bcd_o = 4'd7;
            SEG_8:     bcd_o = 4'd8;
            SEG_9:     bcd_o = 4'd9;
            SEG_BLANK: bcd_o = BCD_BLANK;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Samples a multiplexed 7-segment bus (segment lines + one-hot digit strobes),
// waits for each digit to settle, decodes it back to BCD, assembles a whole
// scan frame and publishes it atomically.
//
// Parameters:
//   NUM_DIGITS     digits per scan frame; strobe bit 0 marks the frame start
//   SETTLE_CYCLES  consecutive identical samples before a digit is captured
//                  (2..255)
//
// Ports:
//   clk_i          system clock
//   rst_n_i        synchronous active-low reset
//   seg_i   [6:0]  segment lines, ABCDEFG
//   an_i    [N-1:0] digit strobes, one-hot or zero
//   digits_o       last good frame, digit i at [4i+3:4i]
//   frame_valid_o  one-cycle pulse when digits_o updates
//   frame_err_o    one-cycle pulse when a frame is rejected
//   locked_o       high while the scan tracker is not hunting for a frame start
//
// Build option:
//   SEG7DEC_ACTIVE_LOW_EN  when defined, seg_i and an_i are inverted at the
//                          input register (common-anode boards).
// -----------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   an_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic                    frame_valid_o,
    output logic                    frame_err_o,
    output logic                    locked_o
);

    localparam int unsigned           IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CAP_CNT  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
    localparam logic [NUM_DIGITS-1:0] AN_FIRST = NUM_DIGITS'(1);

    // ---------------------------------------------------------------- inputs
    logic [6:0]            seg_in;
    logic [NUM_DIGITS-1:0] an_in;

`ifdef SEG7DEC_ACTIVE_LOW_EN
    assign seg_in = ~seg_i;
    assign an_in  = ~an_i;
`else
    assign seg_in = seg_i;
    assign an_in  = an_i;
`endif

    logic [6:0]            s_seg_q, prev_seg_q;
    logic [NUM_DIGITS-1:0] s_an_q,  prev_an_q;

    // One register stage for the pins, one more to detect sample changes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s_seg_q    <= '0;
            s_an_q     <= '0;
            prev_seg_q <= '0;
            prev_an_q  <= '0;
        end else begin
            s_seg_q    <= seg_in;
            s_an_q     <= an_in;
            prev_seg_q <= s_seg_q;
            prev_an_q  <= s_an_q;
        end
    end

    // ---------------------------------------------------------------- decode
    logic [3:0] dec_bcd;
    logic       dec_legal;

    seg7_to_bcd u_dec (
        .seg_i   (s_seg_q),
        .bcd_o   (dec_bcd),
        .legal_o (dec_legal)
    );

    // ---------------------------------------------------------------- state
    state_e                     state_q,  state_d;
    logic [IDX_W-1:0]           idx_q,    idx_d;
    logic [CNT_W-1:0]           cnt_q,    cnt_d;
    logic                       err_q,    err_d;
    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic                       frame_valid_q, frame_valid_d;
    logic                       frame_err_q,   frame_err_d;

    logic                  same;
    logic [NUM_DIGITS-1:0] an_cur;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign same   = ({s_seg_q, s_an_q} == {prev_seg_q, prev_an_q});
    assign an_cur = AN_FIRST << idx_q;
    // Only meaningful while idx_q != LAST_IDX; the shift would run off the end.
    assign an_nxt = AN_FIRST << (idx_q + 1'b1);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        err_d         = err_q;
        shadow_d      = shadow_q;
        digits_d      = digits_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        // Settle counter: restart on any change of the sampled bus, else
        // count up and stick at the top.
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            SYNC: begin
                if (s_an_q == AN_FIRST) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (s_an_q == '0) begin
                    // Inter-digit blanking: wait for the strobe to come back.
                    cnt_d = '0;
                end else if (s_an_q == an_cur) begin
                    // Capture on the SETTLE_CYCLES-th identical sample.
                    if (same && (cnt_q == CAP_CNT)) begin
                        shadow_d[idx_q] = dec_bcd;
                        err_d           = err_q | ~dec_legal;
                        state_d         = HOLD;
                        if (idx_q == LAST_IDX) begin
                            // shadow_d already holds the digit just captured,
                            // so the commit lands on the next cycle.
                            if (err_d) begin
                                frame_err_d = 1'b1;
                            end else begin
                                digits_d      = shadow_d;
                                frame_valid_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = SYNC;
                end
            end

            HOLD: begin
                if ((s_an_q == an_cur) || (s_an_q == '0)) begin
                    state_d = HOLD;
                end else if ((idx_q != LAST_IDX) && (s_an_q == an_nxt)) begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else if ((idx_q == LAST_IDX) && (s_an_q == AN_FIRST)) begin
                    // Legal wrap into the next frame.
                    idx_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    // Repeated, backwards, skipped or multi-hot strobe.
                    frame_err_d = 1'b1;
                    state_d     = SYNC;
                end
            end

            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= SYNC;
            idx_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            shadow_q      <= '0;
            digits_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            shadow_q      <= shadow_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign digits_o      = digits_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_err_o   = frame_err_q;
    assign locked_o      = (state_q != SYNC);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Drives scan frames built from digit values, records every frame_valid /
// frame_err pulse with its cycle stamp, and compares against frame-level
// expectations derived from the digit values and scan sequence.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic [6:0]      seg_i;
    logic [ND-1:0]   an_i;
    logic [4*ND-1:0] digits_o;
    logic            frame_valid_o;
    logic            frame_err_o;
    logic            locked_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .seg_i         (seg_i),
        .an_i          (an_i),
        .digits_o      (digits_o),
        .frame_valid_o (frame_valid_o),
        .frame_err_o   (frame_err_o),
        .locked_o      (locked_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Every output pulse, stamped with the cycle count.
    typedef struct {
        int          cyc;
        bit          is_err;
        logic [15:0] digits;
        logic        locked;
    } ev_t;
    ev_t ev_q[$];

    always @(negedge clk_i) begin
        ev_t e;
        e.cyc    = cyc;
        e.digits = digits_o;
        e.locked = locked_o;
        if (frame_valid_o === 1'b1) begin
            e.is_err = 1'b0;
            ev_q.push_back(e);
        end
        if (frame_err_o === 1'b1) begin
            e.is_err = 1'b1;
            ev_q.push_back(e);
        end
    end

    // Digit value -> pattern; value 10 stands for a blank digit.
    function automatic logic [6:0] pat_of(input int v);
        case (v)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            7:       return 7'b1110000;
            8:       return 7'b1111111;
            9:       return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] p);
        for (int i = 0; i <= 10; i++) if (p == pat_of(i)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present a bus value (just after a rising edge) and hold it for n edges.
    task automatic step(input logic [6:0] s, input logic [ND-1:0] a, input int n);
        seg_i = s;
        an_i  = a;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One full scan: each strobe 10 cycles then a 2-cycle blank gap. A glitch
    // digit shows gpat for 2 cycles before its real pattern. t_last is the
    // cycle at which the last digit's final pattern reaches the pins.
    task automatic send_frame(input logic [ND-1:0][6:0] pats, input int glitch_pos,
                              input logic [6:0] gpat, output int t_last);
        logic [ND-1:0] a;
        t_last = 0;
        for (int i = 0; i < ND; i++) begin
            a    = '0;
            a[i] = 1'b1;
            if (i == glitch_pos) begin
                step(gpat, a, 2);
                t_last = cyc;
                step(pats[i], a, 8);
            end else begin
                t_last = cyc;
                step(pats[i], a, 10);
            end
            step(7'b0, '0, 2);
        end
    endtask

    task automatic rand_frame(output logic [ND-1:0][6:0] p, output logic [15:0] e);
        int v;
        for (int i = 0; i < ND; i++) begin
            v          = int'($urandom_range(0, 10));
            p[i]       = pat_of(v);
            e[4*i +: 4] = (v == 10) ? 4'hF : 4'(v);
        end
    endtask

    // Exactly one pulse expected since the last call.
    task automatic expect_ev(input string tag, input bit exp_err, input int exp_cyc,
                             input logic [15:0] exp_dig, input logic exp_lock);
        check({tag, ".pulses"}, 32'(ev_q.size()), 32'd1);
        if (ev_q.size() > 0) begin
            check({tag, ".is_err"}, 32'(ev_q[0].is_err), 32'(exp_err));
            check({tag, ".cycle"},  32'(ev_q[0].cyc),    32'(exp_cyc));
            check({tag, ".digits"}, 32'(ev_q[0].digits), 32'(exp_dig));
            check({tag, ".locked"}, 32'(ev_q[0].locked), 32'(exp_lock));
        end
        ev_q.delete();
    endtask

    // Strobe 0, gap, then an out-of-order strobe: rejected two cycles later.
    task automatic bad_seq(input string tag, input logic [ND-1:0] bad_an, input logic [15:0] good);
        int t;
        step(pat_of(int'($urandom_range(0, 9))), 4'b0001, 10);
        step(7'b0, '0, 2);
        t = cyc;
        step(pat_of(int'($urandom_range(0, 9))), bad_an, 4);
        expect_ev(tag, 1'b1, t + 2, good, 1'b0);
        check({tag, ".locked_after"}, 32'(locked_o), 32'd0);
        step(7'b0, '0, 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks", checks);
        $fatal(1, "time limit");
    end

    initial begin
        logic [ND-1:0][6:0] pats;
        logic [15:0]        expv;
        logic [15:0]        last_good;
        logic [6:0]         gp;
        logic [ND-1:0]      bad_an;
        int                 t;
        int                 pos;
        int                 kind;

        // ---- reset state
        rst_n_i = 1'b0;
        seg_i   = '0;
        an_i    = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset.digits", 32'(digits_o), 32'h0);
        check("reset.valid",  32'(frame_valid_o), 32'd0);
        check("reset.err",    32'(frame_err_o), 32'd0);
        check("reset.locked", 32'(locked_o), 32'd0);
        rst_n_i = 1'b1;
        ev_q.delete();
        step(7'b0, '0, 2);

        // ---- clean scan 5,4,2,1
        pats = {pat_of(1), pat_of(2), pat_of(4), pat_of(5)};
        send_frame(pats, -1, 7'b0, t);
        expect_ev("clean", 1'b0, t + SC + 2, 16'h1245, 1'b1);
        last_good = 16'h1245;

        // ---- glitch: digit 1 shows 8 briefly, then 4
        send_frame(pats, 1, pat_of(8), t);
        expect_ev("glitch", 1'b0, t + SC + 2, 16'h1245, 1'b1);

        // ---- illegal pattern on digit 2
        pats[2] = 7'b1000001;
        send_frame(pats, -1, 7'b0, t);
        expect_ev("illegal", 1'b1, t + SC + 2, last_good, 1'b1);
        check("illegal.locked_after", 32'(locked_o), 32'd1);
        rand_frame(pats, expv);
        send_frame(pats, -1, 7'b0, t);
        expect_ev("after_illegal", 1'b0, t + SC + 2, expv, 1'b1);
        last_good = expv;

        // ---- bad sequence: strobe 0 then strobe 2, then resync
        bad_seq("badseq", 4'b0100, last_good);
        rand_frame(pats, expv);
        send_frame(pats, -1, 7'b0, t);
        expect_ev("resync", 1'b0, t + SC + 2, expv, 1'b1);
        last_good = expv;

        // ---- blank last digit
        rand_frame(pats, expv);
        pats[3]      = 7'b0000000;
        expv[15:12]  = 4'hF;
        send_frame(pats, -1, 7'b0, t);
        expect_ev("blank", 1'b0, t + SC + 2, expv, 1'b1);
        last_good = expv;

        // ---- reset in the middle of a frame
        step(pat_of(7), 4'b0001, 10);
        step(7'b0, '0, 2);
        step(pat_of(3), 4'b0010, 5);
        rst_n_i = 1'b0;
        step(7'b0, '0, 2);
        check("midreset.digits", 32'(digits_o), 32'h0);
        check("midreset.valid",  32'(frame_valid_o), 32'd0);
        check("midreset.err",    32'(frame_err_o), 32'd0);
        check("midreset.locked", 32'(locked_o), 32'd0);
        check("midreset.pulses", 32'(ev_q.size()), 32'd0);
        ev_q.delete();
        rst_n_i = 1'b1;
        step(7'b0, '0, 2);
        rand_frame(pats, expv);
        send_frame(pats, -1, 7'b0, t);
        expect_ev("post_reset", 1'b0, t + SC + 2, expv, 1'b1);
        last_good = expv;

        // ---- randomized mix of scenarios
        for (int n = 0; n < 14; n++) begin
            kind = int'($urandom_range(0, 3));
            rand_frame(pats, expv);
            pos = int'($urandom_range(0, ND - 1));
            case (kind)
                0: begin
                    send_frame(pats, -1, 7'b0, t);
                    expect_ev("rnd_clean", 1'b0, t + SC + 2, expv, 1'b1);
                    last_good = expv;
                end
                1: begin
                    do gp = pat_of(int'($urandom_range(0, 10))); while (gp == pats[pos]);
                    send_frame(pats, pos, gp, t);
                    expect_ev("rnd_glitch", 1'b0, t + SC + 2, expv, 1'b1);
                    last_good = expv;
                end
                2: begin
                    do gp = 7'($urandom); while (is_legal(gp));
                    pats[pos] = gp;
                    send_frame(pats, -1, 7'b0, t);
                    expect_ev("rnd_illegal", 1'b1, t + SC + 2, last_good, 1'b1);
                end
                default: begin
                    case ($urandom_range(0, 2))
                        0:       bad_an = 4'b0100;
                        1:       bad_an = 4'b1000;
                        default: bad_an = 4'b0110;
                    endcase
                    bad_seq("rnd_badseq", bad_an, last_good);
                end
            endcase
        end

        // ---- quiet bus: no stray pulses
        step(7'b0, '0, 20);
        check("idle.pulses", 32'(ev_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the BCD-to-7-segment driver path.
- Samples a multiplexed 7-segment bus (segment lines plus one-hot digit strobes), waits for each digit to settle, and decodes each pattern back to BCD.
- Assembles a full display frame and reports it atomically.
- Used as a loopback checker on the alarm-clock display outputs and in board bring-up.

Parameters:
- NUM_DIGITS, 4: digits per scan frame; strobe index 0 is the frame start.
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is captured; legal range 2..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- seg  input  7  segment lines, active-high; seg[6]=A, seg[5]=B, …, seg[0]=G.
- an  input  NUM_DIGITS  digit strobes, active-high, expected one-hot or zero.
- digits  output  4*NUM_DIGITS  last good frame; digit i at [4i+3:4i].
- frame_valid  output  1  one-cycle pulse when digits updates.
- frame_err  output  1  one-cycle pulse on a rejected frame.
- locked  output  1  high while not in SYNC.

Behaviour:
- Reset (rst_n low at a clk edge):
  - digits=0, frame_valid=0, frame_err=0, locked=0.
  - state=SYNC, idx=0, cnt=0, internal sample registers cleared.
  - A reset mid-frame discards the partial frame; digits reverts to 0.
- Input register:
  - seg and an are registered once into s_seg/s_an; all logic below uses these.
- Pattern decode (ABCDEFG):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - 0000000 = blank, decodes to 4'hF, legal.
  - Any other pattern is illegal.
- Settle counter cnt:
  - Cleared on entry to SETTLE and whenever {s_seg,s_an} differs from the previous cycle's value.
  - Otherwise increments, saturating.
  - Capture occurs in the cycle cnt==SETTLE_CYCLES-1, i.e. the SETTLE_CYCLES-th consecutive identical sample.
- States:
  - SYNC:
    - Wait for s_an==1<<0; then idx=0, clear the frame-error flag, go to SETTLE.
  - SETTLE:
    - s_an==0: clear cnt, stay (inter-digit blanking).
    - s_an==1<<idx: count; on capture, write the decoded value to shadow[idx], OR illegal-pattern into the sticky err flag, go to HOLD.
    - Any other s_an: frame_err pulse, go to SYNC.
  - HOLD:
    - s_an==1<<idx or 0: stay.
    - s_an==1<<(idx+1) with idx<NUM_DIGITS-1: idx++, go to SETTLE.
    - s_an==1<<0 with idx==NUM_DIGITS-1: idx=0, clear err, go to SETTLE.
    - Anything else, including a non-one-hot strobe: frame_err pulse, go to SYNC.
- Commit:
  - Triggered by capture of idx==NUM_DIGITS-1.
  - Next cycle, if err is clear: digits<=shadow (including the just-captured digit), frame_valid=1.
  - Next cycle, if err is set: frame_err=1, digits unchanged, state stays HOLD (lock kept).
  - frame_valid and frame_err are never high together.
- Latency: pin change to frame_valid = 1 (input register) + SETTLE_CYCLES + 1 cycles, measured from the last digit's stable value.
- Wrap-around:
  - idx wraps NUM_DIGITS-1 to 0 only through a legal strobe sequence.
  - A repeated strobe, or one that goes backwards, is a frame error.

Optional Feature:
- Macro SEG7DEC_ACTIVE_LOW_EN:
  - Defined: seg and an are inverted at the input register (common-anode boards); everything downstream is unchanged.
  - Undefined: inputs are used as-is, active-high.

Decomposition:
- Package seg7_pkg holds:
  - The ten digit pattern constants plus SEG_BLANK.
  - BCD_BLANK=4'hF.
  - The state enum typedef {SYNC, SETTLE, HOLD}.
- One combinational sub-module, seg7_to_bcd: input 7-bit pattern; outputs 4-bit BCD and a legal flag.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-frame → digits=16'h0000, frame_valid=0, frame_err=0, locked=0; the next full frame decodes normally.
- Clean scan: NUM_DIGITS=4, SETTLE_CYCLES=4, each strobe held 10 cycles with a 2-cycle gap, showing 5,4,2,1 for idx 0..3 → one frame_valid exactly 6 cycles after digit 3's pattern appears at the pins; digits=16'h1245.
- Glitch: digit 1 shows 8 for 2 cycles, then 4 for 8 cycles → captured value is 4, not 8; digits=16'h1245.
- Illegal pattern: digit 2 = 1000001 → frame_err pulse, frame_valid stays 0, digits holds its previous value, locked stays 1; the next clean frame commits.
- Bad sequence: strobe 0 then strobe 2 → frame_err pulse and locked=0 the cycle after the registered bad strobe; resync on the next strobe 0.
- Blank digit: digit 3 = 0000000 → digits[15:12]=4'hF, frame_valid asserted, no error.
